cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer.sv | 101 ++++++++++
 tb/tb_cpu_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Four-phase instruction sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK, with a HALT opcode.
// Optional macro CPU_SEQ_JUMP_EN turns opcode 7 into a JUMP to {0, IR[7:0]}.
module cpu_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       instr_valid,
  input  logic [8:0] instr_data,
  input  logic       resume,
  output logic       instr_ready,
  output logic [8:0] pc,
  output logic       reg_write,
  output logic [2:0] alu_op,
  output logic       is_add,
  output logic       is_imm,
  output logic [2:0] dest_addr,
  output logic [2:0] src1_addr,
  output logic [2:0] src2_addr,
  output logic [7:0] imm_val,
  output logic       halted
);

  typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

  state_t     state, state_next;
  logic [8:0] ir;
  logic [3:0] opcode;
  logic       accept;
  logic [2:0] dec_alu_op;
  logic       dec_is_add;
  logic       dec_is_imm;

  assign opcode = ir[4:1];
  assign accept = (state == IDLE) && instr_valid;

  // Register-address and immediate fields only change when a new IR is latched
  assign src1_addr = {1'b0, ir[8:7]};
  assign dest_addr = {1'b0, ir[6:5]};
  assign src2_addr = {1'b0, ir[1:0]};
  assign imm_val   = ir[7:0];

  assign instr_ready = (state == IDLE) && RESET;
  assign halted      = (state == HALT);
  assign reg_write   = (state == WRITEBACK) && (opcode <= 4'd5);

  always_comb begin
    dec_alu_op = 3'b000;
    dec_is_add = 1'b1;
    dec_is_imm = 1'b0;
    case (instr_data[4:1])
      4'd0: dec_is_imm = 1'b1;
      4'd2: dec_alu_op = 3'b001;
      4'd3: begin
        dec_alu_op = 3'b001;
        dec_is_add = 1'b0;
      end
      4'd4: dec_alu_op = 3'b010;
      4'd5: dec_alu_op = 3'b011;
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (instr_valid) state_next = DECODE;
      DECODE:    state_next = EXECUTE;
      EXECUTE:   state_next = WRITEBACK;
      WRITEBACK: state_next = (opcode == 4'd6) ? HALT : IDLE;
      HALT:      if (resume) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state  <= IDLE;
      ir     <= 9'd0;
      pc     <= 9'd0;
      alu_op <= 3'b000;
      is_add <= 1'b0;
      is_imm <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        ir     <= instr_data;
        alu_op <= dec_alu_op;
        is_add <= dec_is_add;
        is_imm <= dec_is_imm;
      end
      // pc moves once per instruction, as WRITEBACK is left; 9-bit add wraps 508 to 0
      if (state == WRITEBACK) begin
`ifdef CPU_SEQ_JUMP_EN
        pc <= (opcode == 4'd7) ? {1'b0, ir[7:0]} : pc + 9'd4;
`else
        pc <= pc + 9'd4;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; expected values are hand-computed from the instruction encodings.
module tb_cpu_sequencer;

  logic       CLK;
  logic       RESET;
  logic       instr_valid;
  logic [8:0] instr_data;
  logic       resume;
  logic       instr_ready;
  logic [8:0] pc;
  logic       reg_write;
  logic [2:0] alu_op;
  logic       is_add;
  logic       is_imm;
  logic [2:0] dest_addr;
  logic [2:0] src1_addr;
  logic [2:0] src2_addr;
  logic [7:0] imm_val;
  logic       halted;

  int checks;
  int failures;
  logic [8:0] exp_pc;

  cpu_sequencer dut (
    .CLK(CLK),
    .RESET(RESET),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .resume(resume),
    .instr_ready(instr_ready),
    .pc(pc),
    .reg_write(reg_write),
    .alu_op(alu_op),
    .is_add(is_add),
    .is_imm(is_imm),
    .dest_addr(dest_addr),
    .src1_addr(src1_addr),
    .src2_addr(src2_addr),
    .imm_val(imm_val),
    .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Bounded wait for IDLE, then present one instruction for a single edge; returns in the DECODE cycle
  task automatic offer(input logic [8:0] data, input string tag);
    for (int i = 0; i < 8 && !instr_ready; i++) step();
    check({tag, "_ready"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr_data  = data;
    step();
    instr_valid = 1'b0;
    instr_data  = 9'h1FF;
  endtask

  // Samples the DECODE/EXECUTE/WRITEBACK cycles and ends in the 4th cycle after accept
  task automatic finish_instr(input logic expect_write, input logic [8:0] pc_after, input string tag);
    logic [2:0] seen;
    seen = 3'b000;
    for (int i = 0; i < 3; i++) begin
      seen[i] = reg_write;
      step();
    end
    check({tag, "_regwrite"}, seen, expect_write ? 3'b100 : 3'b000);
    check({tag, "_pc"}, pc, pc_after);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    RESET       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 9'h000;
    resume      = 1'b0;

    step();
    step();
    check("rst_ready", instr_ready, 0);
    check("rst_outputs",
          {pc, reg_write, alu_op, is_add, is_imm, dest_addr, src1_addr, src2_addr, imm_val, halted},
          0);
    RESET = 1'b1;
    #1;
    check("rst_release_ready", instr_ready, 1);

    // opcode 0: add immediate
    offer(9'h000, "op0");
    check("op0_ready_drop", instr_ready, 0);
    check("op0_ctrl", {alu_op, is_add, is_imm}, 5'b000_1_1);
    finish_instr(1'b1, 9'd4, "op0");
    check("op0_ready_again", instr_ready, 1);

    // opcode 3: subtract registers
    offer(9'h186, "op3");
    check("op3_ctrl", {alu_op, is_add, is_imm}, 5'b001_0_0);
    check("op3_addr", {src1_addr, src2_addr, dest_addr}, {3'd3, 3'd2, 3'd0});
    check("op3_imm", imm_val, 8'h86);
    finish_instr(1'b1, 9'd8, "op3");

    // opcode 6: halt, instruction offers ignored until resume
    offer(9'h00C, "halt");
    check("halt_ctrl", {alu_op, is_add, is_imm}, 5'b000_1_0);
    finish_instr(1'b0, 9'd12, "halt");
    check("halt_flag", halted, 1);
    check("halt_ready", instr_ready, 0);
    instr_valid = 1'b1;
    instr_data  = 9'h000;
    step();
    step();
    step();
    check("halt_hold_flag", halted, 1);
    check("halt_hold_pc", pc, 9'd12);
    check("halt_hold_fields", {alu_op, is_add, is_imm, imm_val}, {5'b000_1_0, 8'h0C});
    instr_valid = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_flag", halted, 0);
    check("resume_ready", instr_ready, 1);

    // NOPs (opcode 8) walk pc up to 508 and across the wrap
    exp_pc = 9'd12;
    while (exp_pc != 9'd508) begin
      exp_pc = exp_pc + 9'd4;
      offer(9'h010, "nop");
      finish_instr(1'b0, exp_pc, "nop");
    end
    check("nop_at_508", pc, 9'd508);
    offer(9'h010, "nop_wrap");
    finish_instr(1'b0, 9'd0, "nop_wrap");

    // opcode 7: jump when enabled, otherwise NOP
    offer(9'h0AE, "op7");
    check("op7_imm", imm_val, 8'hAE);
`ifdef CPU_SEQ_JUMP_EN
    finish_instr(1'b0, 9'h0AE, "op7");
`else
    finish_instr(1'b0, 9'd4, "op7");
`endif

    // opcode 1 aborted by reset during EXECUTE
    offer(9'h002, "abort");
    check("abort_ctrl", {alu_op, is_add, is_imm}, 5'b000_1_0);
    step();
    RESET = 1'b0;
    #1;
    check("abort_ready_low", instr_ready, 0);
    step();
    check("abort_outputs",
          {pc, reg_write, alu_op, is_add, is_imm, dest_addr, src1_addr, src2_addr, imm_val, halted},
          0);
    RESET = 1'b1;
    #1;
    check("abort_ready_back", instr_ready, 1);
    step();
    check("abort_no_write", reg_write, 0);
    step();
    check("abort_idle", {instr_ready, reg_write, halted}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
